// File: rtl/sysbus_pkg.sv
// Shared definitions for the Sysbus line arbiter: bus tag layout and FSM states.
package sysbus_pkg;

  localparam int         TAG_W    = 13;
  localparam int         RW_BIT   = 12;
  localparam logic [3:0] MEM_TYPE = 4'b0001;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    RDATA = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Tag = {rw, memory type, 8-bit client id}
  function automatic logic [TAG_W-1:0] make_tag(input logic rw, input logic id);
    logic [TAG_W-1:0] tag;
    tag         = '0;
    tag[RW_BIT] = rw;
    tag[11:8]   = MEM_TYPE;
    tag[7:0]    = 8'(id);
    return tag;
  endfunction

endpackage

// File: rtl/sysbus_line_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the client favoured on a tie
// and moves to the other client whenever a grant is accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (accept && (|grant)) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/sysbus_line_arbiter.sv
// Shares one Sysbus port between instruction-fetch (client 0) and data (client 1)
// line requesters; one line read or write at a time, serialised into bus beats.
module sysbus_line_arbiter
  import sysbus_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13,
  parameter int LINE_BEATS = 8,
  localparam int LW = DATA_WIDTH * LINE_BEATS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            c_req_valid,
  output logic [1:0]            c_req_ready,
  input  logic [1:0]            c_req_write,
  input  logic [127:0]          c_req_addr,
  input  logic [2*LW-1:0]       c_req_line,
  output logic [1:0]            c_resp_valid,
  output logic [LW-1:0]         c_resp_line,
  output logic [DATA_WIDTH-1:0] bus_req,
  output logic [TAG_WIDTH-1:0]  bus_reqtag,
  output logic                  bus_reqcyc,
  input  logic                  bus_reqack,
  input  logic [DATA_WIDTH-1:0] bus_resp,
  input  logic [TAG_WIDTH-1:0]  bus_resptag,
  input  logic                  bus_respcyc,
  output logic                  bus_respack
);

  localparam int BW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BEATS - 1);

  // Handshake: a client request is taken in the cycle c_req_valid[i] & c_req_ready[i];
  // a bus request beat moves when bus_reqcyc & bus_reqack; a response beat is consumed
  // when bus_respcyc & bus_respack.
  state_t         state;
  logic [BW-1:0]  beat;
  logic [BW-1:0]  next_beat;
  logic           id_q;
  logic           write_q;
  logic [LW-1:0]  line_q;

  logic [1:0]     arb_req;
  logic [1:0]     grant;
  logic           gid;
  logic           sel_write;
  logic [63:0]    sel_addr;
  logic [LW-1:0]  sel_line;
  logic           idle;

  assign idle      = (state == IDLE) && !reset;
  assign arb_req   = idle ? c_req_valid : 2'b00;
  assign gid       = grant[1];
  assign sel_write = gid ? c_req_write[1] : c_req_write[0];
  assign sel_addr  = gid ? c_req_addr[127:64] : c_req_addr[63:0];
  assign sel_line  = gid ? c_req_line[2*LW-1:LW] : c_req_line[LW-1:0];
  assign next_beat = beat + 1'b1;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (arb_req),
    .accept (idle),
    .grant  (grant)
  );

  assign c_req_ready = grant;
  assign c_resp_line = line_q;
  // Foreign tags belong to other bus masters and are left for them.
  assign bus_respack = (state == RDATA) && bus_respcyc && (bus_resptag == bus_reqtag);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      beat         <= '0;
      id_q         <= 1'b0;
      write_q      <= 1'b0;
      line_q       <= '0;
      bus_req      <= '0;
      bus_reqtag   <= '0;
      bus_reqcyc   <= 1'b0;
      c_resp_valid <= 2'b00;
    end else begin
      c_resp_valid <= 2'b00;
      case (state)
        IDLE: begin
          if (|grant) begin
            id_q       <= gid;
            write_q    <= sel_write;
            line_q     <= sel_line;
            bus_req    <= DATA_WIDTH'(sel_addr & ~64'h3f);
            bus_reqtag <= TAG_WIDTH'(make_tag(sel_write, gid));
            bus_reqcyc <= 1'b1;
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (bus_reqack) begin
            beat <= '0;
            if (write_q) begin
              bus_req <= line_q[DATA_WIDTH-1:0];
              state   <= WDATA;
            end else begin
              bus_req    <= '0;
              bus_reqcyc <= 1'b0;
              state      <= RDATA;
            end
          end
        end
        WDATA: begin
          if (bus_reqack) begin
            if (beat == LAST_BEAT) begin
              beat               <= '0;
              bus_req            <= '0;
              bus_reqcyc         <= 1'b0;
              c_resp_valid[id_q] <= 1'b1;
              state              <= DONE;
            end else begin
              beat    <= next_beat;
              bus_req <= line_q[DATA_WIDTH*int'(next_beat) +: DATA_WIDTH];
            end
          end
        end
        RDATA: begin
          if (bus_respack) begin
            line_q[DATA_WIDTH*int'(beat) +: DATA_WIDTH] <= bus_resp;
            if (beat == LAST_BEAT) begin
              beat               <= '0;
              c_resp_valid[id_q] <= 1'b1;
              state              <= DONE;
            end else begin
              beat <= next_beat;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysbus_line_arbiter.sv
// Directed bench for sysbus_line_arbiter: reads, writes, contention, foreign tags,
// mid-read reset and back-to-back grants.
module tb_sysbus_line_arbiter;

  logic          clk;
  logic          reset;
  logic [1:0]    c_req_valid;
  logic [1:0]    c_req_ready;
  logic [1:0]    c_req_write;
  logic [127:0]  c_req_addr;
  logic [1023:0] c_req_line;
  logic [1:0]    c_resp_valid;
  logic [511:0]  c_resp_line;
  logic [63:0]   bus_req;
  logic [12:0]   bus_reqtag;
  logic          bus_reqcyc;
  logic          bus_reqack;
  logic [63:0]   bus_resp;
  logic [12:0]   bus_resptag;
  logic          bus_respcyc;
  logic          bus_respack;

  int checks;
  int failures;
  logic [63:0] exp_q[$];

  sysbus_line_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .c_req_valid  (c_req_valid),
    .c_req_ready  (c_req_ready),
    .c_req_write  (c_req_write),
    .c_req_addr   (c_req_addr),
    .c_req_line   (c_req_line),
    .c_resp_valid (c_resp_valid),
    .c_resp_line  (c_resp_line),
    .bus_req      (bus_req),
    .bus_reqtag   (bus_reqtag),
    .bus_reqcyc   (bus_reqcyc),
    .bus_reqack   (bus_reqack),
    .bus_resp     (bus_resp),
    .bus_resptag  (bus_resptag),
    .bus_respcyc  (bus_respcyc),
    .bus_respack  (bus_respack)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_small"}, 512'({c_req_ready, c_resp_valid, bus_req, bus_reqtag, bus_reqcyc, bus_respack}), 512'(0));
    chk({tag, "_line"}, c_resp_line, 512'(0));
  endtask

  // Driver: reset pulse, returning at a negedge with reset just released.
  task automatic reset_dut();
    reset       = 1'b1;
    c_req_valid = 2'b00;
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    repeat (2) tick();
    chk_outputs_zero("reset_outputs");
    reset = 1'b0;
  endtask

  // Driver: a read transaction starting at the grant negedge. Immediate address ack,
  // one response beat per cycle of value seed*(i+1). Optionally inserts one foreign-tag
  // beat before matching beat foreign_at, or resets the DUT before beat abort_at.
  task automatic run_read(input string tag, input logic [1:0] exp_gnt, input logic [63:0] exp_addr,
                          input logic [12:0] exp_tag, input logic [63:0] seed, input bit keep,
                          input int foreign_at, input int abort_at);
    logic [511:0] exp_line;
    exp_line = '0;
    #1 chk({tag, "_ready"}, 512'(c_req_ready), 512'(exp_gnt));
    tick();
    if (!keep) c_req_valid = c_req_valid & ~exp_gnt;
    chk({tag, "_ready_addr"}, 512'(c_req_ready), 512'(0));
    chk({tag, "_reqcyc"}, 512'(bus_reqcyc), 512'(1));
    chk({tag, "_addr"}, 512'(bus_req), 512'(exp_addr));
    chk({tag, "_tag"}, 512'(bus_reqtag), 512'(exp_tag));
    bus_reqack = 1'b1;
    tick();
    bus_reqack = 1'b0;
    chk({tag, "_reqcyc_rd"}, 512'(bus_reqcyc), 512'(0));
    for (int i = 0; i < 8; i++) begin
      if (i == foreign_at) begin
        bus_respcyc = 1'b1;
        bus_resptag = 13'h1055;
        bus_resp    = 64'hDEAD_BEEF_DEAD_BEEF;
        #1 chk({tag, "_foreign_ack"}, 512'(bus_respack), 512'(0));
        tick();
      end
      if (i == abort_at) begin
        bus_respcyc = 1'b0;
        c_req_valid = 2'b00;
        reset       = 1'b1;
        tick();
        chk_outputs_zero({tag, "_abort"});
        reset = 1'b0;
        tick();
        chk({tag, "_abort_noresp"}, 512'(c_resp_valid), 512'(0));
        chk({tag, "_abort_reqcyc"}, 512'(bus_reqcyc), 512'(0));
        return;
      end
      bus_respcyc = 1'b1;
      bus_resptag = exp_tag;
      bus_resp    = seed * 64'(i + 1);
      exp_line[64*i +: 64] = seed * 64'(i + 1);
      #1 chk({tag, "_respack"}, 512'(bus_respack), 512'(1));
      if (i == 7) chk({tag, "_early_resp"}, 512'(c_resp_valid), 512'(0));
      tick();
    end
    bus_respcyc = 1'b0;
    chk({tag, "_resp_valid"}, 512'(c_resp_valid), 512'(exp_gnt));
    chk({tag, "_resp_line"}, c_resp_line, exp_line);
    tick();
    chk({tag, "_resp_pulse"}, 512'(c_resp_valid), 512'(0));
  endtask

  initial begin
    int hold;
    checks      = 0;
    failures    = 0;
    c_req_write = 2'b00;
    c_req_addr  = '0;
    c_req_line  = '0;
    bus_resp    = '0;
    bus_resptag = '0;
    reset_dut();

    // Single read, client 0; grant in the first cycle out of reset
    c_req_addr[63:0] = 64'h1000_0047;
    c_req_valid      = 2'b01;
    run_read("rd0", 2'b01, 64'h1000_0040, 13'h0100, 64'h11, 1'b0, -1, -1);

    // Write, client 1, with the bus stalling beat 3 for two cycles
    c_req_addr[127:64] = 64'h2000_0085;
    for (int i = 0; i < 8; i++) c_req_line[512 + 64*i +: 64] = 64'(i * 256);
    c_req_write = 2'b10;
    c_req_valid = 2'b10;
    exp_q.push_back(64'h2000_0080);
    for (int i = 0; i < 8; i++) exp_q.push_back(64'(i * 256));
    #1 chk("wr_ready", 512'(c_req_ready), 512'(2'b10));
    tick();
    c_req_valid = 2'b00;
    chk("wr_tag", 512'(bus_reqtag), 512'(13'h1101));
    hold = 0;
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      chk("wr_reqcyc", 512'(bus_reqcyc), 512'(1));
      chk("wr_respack", 512'(bus_respack), 512'(0));
      if (exp_q.size() == 5 && hold < 2) begin
        bus_reqack = 1'b0;
        hold++;
        chk("wr_hold", 512'(bus_req), 512'(exp_q[0]));
      end else begin
        bus_reqack = 1'b1;
        chk("wr_beat", 512'(bus_req), 512'(exp_q.pop_front()));
      end
      tick();
    end
    bus_reqack = 1'b0;
    chk("wr_beats_left", 512'(exp_q.size()), 512'(0));
    chk("wr_resp_valid", 512'(c_resp_valid), 512'(2'b10));
    chk("wr_reqcyc_done", 512'(bus_reqcyc), 512'(0));
    tick();
    chk("wr_resp_pulse", 512'(c_resp_valid), 512'(0));
    c_req_write = 2'b00;

    // Contention: both clients hold valid for six reads after a fresh reset
    reset_dut();
    c_req_addr[63:0]   = 64'h1000_0047;
    c_req_addr[127:64] = 64'h3000_00FF;
    c_req_valid        = 2'b11;
    run_read("ct_a", 2'b01, 64'h1000_0040, 13'h0100, 64'h21, 1'b1, -1, -1);
    run_read("ct_b", 2'b10, 64'h3000_00C0, 13'h0101, 64'h31, 1'b1, -1, -1);
    run_read("ct_c", 2'b01, 64'h1000_0040, 13'h0100, 64'h41, 1'b1, -1, -1);
    run_read("ct_d", 2'b10, 64'h3000_00C0, 13'h0101, 64'h51, 1'b1, -1, -1);
    run_read("ct_e", 2'b01, 64'h1000_0040, 13'h0100, 64'h61, 1'b1, -1, -1);
    run_read("ct_f", 2'b10, 64'h3000_00C0, 13'h0101, 64'h71, 1'b1, -1, -1);
    c_req_valid = 2'b00;
    tick();
    chk("ct_idle_ready", 512'(c_req_ready), 512'(0));

    // Foreign tag interleaved before matching beat 3
    c_req_valid = 2'b01;
    run_read("fr", 2'b01, 64'h1000_0040, 13'h0100, 64'h0101, 1'b0, 3, -1);

    // Reset after four response beats, then a clean read
    c_req_valid = 2'b01;
    run_read("ab", 2'b01, 64'h1000_0040, 13'h0100, 64'h0202, 1'b0, -1, 4);
    c_req_valid = 2'b01;
    run_read("ab_new", 2'b01, 64'h1000_0040, 13'h0100, 64'h7, 1'b0, -1, -1);

    // Back-to-back: client 0 keeps valid high, regrant the cycle after DONE
    c_req_valid = 2'b01;
    run_read("bb_a", 2'b01, 64'h1000_0040, 13'h0100, 64'h0303, 1'b1, -1, -1);
    run_read("bb_b", 2'b01, 64'h1000_0040, 13'h0100, 64'h0404, 1'b0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
